// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: function codes,
// FSM state encoding and the default datapath width.
package mips_pkg;

   localparam int SIZE_DEF = 32;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SIGN = 2'd2
   } md_state_e;

   function automatic logic is_md_fn(input logic [5:0] fn);
      return (fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) ||
             (fn == FN_MTLO) || (fn == FN_MULT) || (fn == FN_MULTU) ||
             (fn == FN_DIV)  || (fn == FN_DIVU);
   endfunction

   function automatic logic is_arith_fn(input logic [5:0] fn);
      return (fn == FN_MULT) || (fn == FN_MULTU) ||
             (fn == FN_DIV)  || (fn == FN_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 magnitude datapath: shift-add multiply, restoring divide, and the
// final sign fixup of product / quotient / remainder.
module muldiv_datapath
   import mips_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            is_div,
   input  logic            is_signed,
   input  logic [SIZE-1:0] op_a,
   input  logic [SIZE-1:0] op_b,
   output logic [SIZE-1:0] res_hi,
   output logic [SIZE-1:0] res_lo
);

   logic [SIZE-1:0] acc_hi_q, acc_hi_d;
   logic [SIZE-1:0] acc_lo_q, acc_lo_d;
   logic [SIZE-1:0] opd_q, opd_d;
   logic            is_div_q, is_div_d;
   logic            neg_q_q, neg_q_d;
   logic            neg_r_q, neg_r_d;

   logic            a_neg, b_neg;
   logic [SIZE-1:0] a_mag, b_mag, addend;
   logic [SIZE:0]   sum, rem_sh, diff;
   logic [2*SIZE-1:0] prod, prod_fix;
   logic [SIZE-1:0] q_fix, r_fix;

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      a_neg = is_signed & op_a[SIZE-1];
      b_neg = is_signed & op_b[SIZE-1];
      a_mag = a_neg ? -op_a : op_a;
      b_mag = b_neg ? -op_b : op_b;

      addend = acc_lo_q[0] ? opd_q : '0;
      sum    = {1'b0, acc_hi_q} + {1'b0, addend};
      rem_sh = {acc_hi_q, acc_lo_q[SIZE-1]};
      diff   = rem_sh - {1'b0, opd_q};

      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opd_d    = opd_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;

      if (load) begin
         acc_hi_d = '0;
         acc_lo_d = is_div ? a_mag : b_mag;
         opd_d    = is_div ? b_mag : a_mag;
         is_div_d = is_div;
         neg_q_d  = a_neg ^ b_neg;
         neg_r_d  = a_neg;
      end else if (step) begin
         if (is_div_q) begin
            // A clear top bit of diff means the trial subtract did not borrow.
            acc_hi_d = diff[SIZE] ? rem_sh[SIZE-1:0] : diff[SIZE-1:0];
            acc_lo_d = {acc_lo_q[SIZE-2:0], ~diff[SIZE]};
         end else begin
            acc_hi_d = sum[SIZE:1];
            acc_lo_d = {sum[0], acc_lo_q[SIZE-1:1]};
         end
      end
   end

   always_comb begin
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = neg_q_q ? -prod : prod;
      q_fix    = neg_q_q ? -acc_lo_q : acc_lo_q;
      r_fix    = neg_r_q ? -acc_hi_q : acc_hi_q;
      res_hi   = is_div_q ? r_fix : prod_fix[2*SIZE-1:SIZE];
      res_lo   = is_div_q ? q_fix : prod_fix[SIZE-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opd_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opd_q    <= opd_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers; the FSM
// sequences muldiv_datapath and stalls the pipeline on HI/LO access while busy.
module ex_muldiv
   import mips_pkg::*;
#(
   parameter int SIZE     = SIZE_DEF,
   parameter int SIZE_FNC = 6,
   parameter int CNT_W    = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                md_en,
   input  logic [SIZE_FNC-1:0] funcion,
   input  logic [SIZE-1:0]     op_a,
   input  logic [SIZE-1:0]     op_b,
   input  logic                flush,
   output logic [SIZE-1:0]     hi,
   output logic [SIZE-1:0]     lo,
   output logic [SIZE-1:0]     mf_data,
   output logic                busy,
   output logic                stall,
   output logic                done
);

   md_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SIZE-1:0] hi_q, hi_d;
   logic [SIZE-1:0] lo_q, lo_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic            dp_load, dp_step, fn_div, fn_signed;
   logic [SIZE-1:0] res_hi, res_lo;

   assign fn_div    = (funcion == FN_DIV)  || (funcion == FN_DIVU);
   assign fn_signed = (funcion == FN_MULT) || (funcion == FN_DIV);

   muldiv_datapath #(.SIZE(SIZE)) u_dp (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (dp_load),
      .step      (dp_step),
      .is_div    (fn_div),
      .is_signed (fn_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dp_load = 1'b0;
      dp_step = 1'b0;

      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (md_en) begin
                  if (funcion == FN_MTHI) begin
                     hi_d = op_a;
                  end else if (funcion == FN_MTLO) begin
                     lo_d = op_a;
                  end else if (is_arith_fn(funcion)) begin
                     // Divide by zero skips iteration and completes next edge.
                     if (fn_div && (op_b == '0)) begin
                        hi_d   = op_a;
                        lo_d   = '1;
                        done_d = 1'b1;
                     end else begin
                        dp_load = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                     end
                  end
               end
            end
            ST_RUN: begin
               dp_step = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(SIZE - 1)) begin
                  state_d = ST_SIGN;
               end
            end
            ST_SIGN: begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      mf_data = '0;
      if (md_en && (funcion == FN_MFHI)) begin
         mf_data = hi_q;
      end else if (md_en && (funcion == FN_MFLO)) begin
         mf_data = lo_q;
      end
   end

   assign stall = md_en & is_md_fn(funcion) & (busy_q | (state_q != ST_IDLE));
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a vector table of mult/div results and
// latencies, plus hand sequences for moves, stalls, flush and mid-op reset.
module tb_ex_muldiv;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        md_en;
   logic [5:0]  funcion;
   logic [31:0] op_a, op_b;
   logic        flush;
   logic [31:0] hi, lo, mf_data;
   logic        busy, stall, done;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[11];

   ex_muldiv #(.SIZE(32), .SIZE_FNC(6), .CNT_W(6)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .md_en   (md_en),
      .funcion (funcion),
      .op_a    (op_a),
      .op_b    (op_b),
      .flush   (flush),
      .hi      (hi),
      .lo      (lo),
      .mf_data (mf_data),
      .busy    (busy),
      .stall   (stall),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      md_en   = 1'b0;
      funcion = 6'h00;
      op_a    = '0;
      op_b    = '0;
   endtask

   // Issue one mult/div, then count edges until done shows up.
   task automatic run_vec(input vec_t v);
      int lat;
      md_en = 1'b1; funcion = v.fn; op_a = v.a; op_b = v.b;
      #1;
      check({v.name, " stall@issue"}, 32'(stall), 32'd0);
      tick();
      idle_inputs();
      lat = 1;
      check({v.name, " busy@accept"}, 32'(busy), (v.lat > 1) ? 32'd1 : 32'd0);
      while (!done && lat < 60) begin
         tick();
         lat++;
      end
      check({v.name, " latency"}, 32'(lat), 32'(v.lat));
      check({v.name, " hi"}, hi, v.exp_hi);
      check({v.name, " lo"}, lo, v.exp_lo);
      check({v.name, " busy@done"}, 32'(busy), 32'd0);
      tick();
      check({v.name, " done width"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      int seen;

      vecs[0]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, "multu max"};
      vecs[1]  = '{FN_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, "mult -7*3"};
      vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, "div -7/2"};
      vecs[3]  = '{FN_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1,  "divu 100/0"};
      vecs[4]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, "div ovf"};
      vecs[5]  = '{FN_DIVU,  32'd17,       32'd5,        32'd2,        32'd3,        34, "divu 17/5"};
      vecs[6]  = '{FN_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34, "multu shift"};
      vecs[7]  = '{FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, "div 7/-2"};
      vecs[8]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, "mult minsq"};
      vecs[9]  = '{FN_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 34, "divu max/1"};
      vecs[10] = '{FN_DIV,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1,  "div -1/0"};

      rst_n = 1'b0;
      flush = 1'b0;
      idle_inputs();
      #3;
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      check("reset mf_data", mf_data, 32'd0);
      #9 rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Moves in IDLE: write at the edge, read combinationally.
      md_en = 1'b1; funcion = FN_MTHI; op_a = 32'h1234;
      #1 check("mthi stall", 32'(stall), 32'd0);
      tick();
      check("mthi hi", hi, 32'h1234);
      check("mthi busy", 32'(busy), 32'd0);
      check("mthi done", 32'(done), 32'd0);
      funcion = FN_MTLO; op_a = 32'h5678;
      tick();
      check("mtlo lo", lo, 32'h5678);
      check("mtlo hi kept", hi, 32'h1234);
      funcion = FN_MFHI;
      #1 check("mfhi data", mf_data, 32'h1234);
      check("mfhi stall", 32'(stall), 32'd0);
      funcion = FN_MFLO;
      #1 check("mflo data", mf_data, 32'h5678);
      idle_inputs();
      #1 check("mf idle zero", mf_data, 32'd0);

      // MFLO queued 5 cycles into DIVU 17/5.
      tick();
      md_en = 1'b1; funcion = FN_DIVU; op_a = 32'd17; op_b = 32'd5;
      tick();
      idle_inputs();
      repeat (5) tick();
      md_en = 1'b1; funcion = FN_MFLO;
      #1 check("mflo queued stall", 32'(stall), 32'd1);
      n = 0;
      while (stall && n < 60) begin
         tick();
         n++;
      end
      check("mflo stall cycles", 32'(n), 32'd28);
      check("mflo after busy", mf_data, 32'd3);
      check("mflo done same cycle", 32'(done), 32'd1);
      funcion = FN_MFHI;
      #1 check("mfhi after busy", mf_data, 32'd2);
      idle_inputs();
      tick();

      // MULT presented while busy is held until busy falls.
      md_en = 1'b1; funcion = FN_MULTU; op_a = 32'd3; op_b = 32'd5;
      tick();
      funcion = FN_MULT; op_a = 32'hFFFFFFFC; op_b = 32'd6;
      #1;
      n = 0;
      while (stall && n < 60) begin
         tick();
         n++;
      end
      check("queued mult wait", 32'(n), 32'd33);
      check("first mult lo", lo, 32'd15);
      check("first mult done", 32'(done), 32'd1);
      tick();
      idle_inputs();
      check("queued mult busy", 32'(busy), 32'd1);
      n = 1;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      check("queued mult latency", 32'(n), 32'd34);
      check("queued mult hi", hi, 32'hFFFFFFFF);
      check("queued mult lo", lo, 32'hFFFFFFE8);
      tick();

      // Flush ten cycles into RUN: no done, HI/LO untouched.
      md_en = 1'b1; funcion = FN_DIVU; op_a = 32'd1000; op_b = 32'd7;
      tick();
      idle_inputs();
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen++;
         tick();
      end
      check("flush no done", 32'(seen), 32'd0);
      check("flush hi kept", hi, 32'hFFFFFFFF);
      check("flush lo kept", lo, 32'hFFFFFFE8);

      // Flush beats acceptance in the same cycle.
      md_en = 1'b1; funcion = FN_MULTU; op_a = 32'd2; op_b = 32'd2; flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_inputs();
      check("flush+accept busy", 32'(busy), 32'd0);

      // Reset low ten cycles into an operation.
      md_en = 1'b1; funcion = FN_MULTU; op_a = 32'd9; op_b = 32'd9;
      tick();
      idle_inputs();
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      check("midreset hi", hi, 32'd0);
      check("midreset lo", lo, 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen++;
         tick();
      end
      check("midreset no done", 32'(seen), 32'd0);
      check("midreset lo after", lo, 32'd0);
      check("midreset busy after", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
